// File: rtl/lc3b_types.sv
// Shared LC-3b control types: opcode and ALU-op encodings, write mask,
// mux-select constants and the bundle of control outputs with its idle value.
package lc3b_types;

  typedef enum logic [3:0] {
    op_br   = 4'h0,
    op_add  = 4'h1,
    op_ldb  = 4'h2,
    op_stb  = 4'h3,
    op_jsr  = 4'h4,
    op_and  = 4'h5,
    op_ldr  = 4'h6,
    op_str  = 4'h7,
    op_rti  = 4'h8,
    op_not  = 4'h9,
    op_ldi  = 4'ha,
    op_sti  = 4'hb,
    op_jmp  = 4'hc,
    op_shf  = 4'hd,
    op_lea  = 4'he,
    op_trap = 4'hf
  } lc3b_opcode;

  typedef enum logic [2:0] {
    alu_add, alu_and, alu_not, alu_pass, alu_sll, alu_srl, alu_sra
  } lc3b_aluop;

  typedef logic [1:0] lc3b_mem_wmask;

  localparam logic       PCMUX_PLUS2    = 1'b0;
  localparam logic       PCMUX_BRADD    = 1'b1;
  localparam logic       MARMUX_ALU     = 1'b0;
  localparam logic       MARMUX_PC      = 1'b1;
  localparam logic       MDRMUX_ALU     = 1'b0;
  localparam logic       MDRMUX_MEM     = 1'b1;
  localparam logic [1:0] REGMUX_ALU     = 2'd0;
  localparam logic [1:0] REGMUX_MDR     = 2'd1;
  localparam logic [1:0] REGMUX_MDR_B   = 2'd2;
  localparam logic [1:0] ALUMUX_SR2     = 2'd0;
  localparam logic [1:0] ALUMUX_OFFS6   = 2'd2;
  localparam logic       STOREMUX_SR1   = 1'b0;
  localparam logic       STOREMUX_DR    = 1'b1;
  localparam lc3b_mem_wmask WMASK_WORD  = 2'b11;
  localparam lc3b_mem_wmask WMASK_LO    = 2'b01;
  localparam lc3b_mem_wmask WMASK_HI    = 2'b10;

  typedef struct packed {
    logic          load_pc;
    logic          load_ir;
    logic          load_regfile;
    logic          load_mar;
    logic          load_mdr;
    logic          load_cc;
    logic          pcmux_sel;
    logic          marmux_sel;
    logic          mdrmux_sel;
    logic [1:0]    regfilemux_sel;
    logic [1:0]    alumux_sel;
    logic          storemux_sel;
    lc3b_aluop     aluop;
    logic          mem_read;
    logic          mem_write;
    lc3b_mem_wmask mem_byte_enable;
    logic          mem_error;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    load_pc: 1'b0, load_ir: 1'b0, load_regfile: 1'b0, load_mar: 1'b0,
    load_mdr: 1'b0, load_cc: 1'b0, pcmux_sel: PCMUX_PLUS2,
    marmux_sel: MARMUX_ALU, mdrmux_sel: MDRMUX_ALU,
    regfilemux_sel: REGMUX_ALU, alumux_sel: ALUMUX_SR2,
    storemux_sel: STOREMUX_SR1, aluop: alu_pass, mem_read: 1'b0,
    mem_write: 1'b0, mem_byte_enable: WMASK_WORD, mem_error: 1'b0
  };

  function automatic logic is_store_op(lc3b_opcode op);
    return (op == op_str) || (op == op_stb);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Bounded-wait counter for memory handshake states. Held at zero while
// clear is high, counts cycles with mem_resp low, saturates at MEM_TIMEOUT.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_WIDTH    = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic mem_resp,
  output logic expired
);

  localparam logic [TO_WIDTH-1:0] LIMIT = TO_WIDTH'(MEM_TIMEOUT);

  logic [TO_WIDTH-1:0] count;

  // count idle wait cycles, stopping at the limit
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (!mem_resp && (count != LIMIT)) begin
      count <= count + TO_WIDTH'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/lc3b_mc_control.sv
// LC-3b multicycle control unit: fetch/decode sequencing, ALU, branch and
// load/store flows, bounded memory waits and a sticky error state.
// Byte load/store support is enabled by defining LC3B_BYTE_OPS_EN.
module lc3b_mc_control
  import lc3b_types::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_WIDTH    = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       imm_mode,
  input  logic       branch_enable,
  input  logic       mar_lsb,
  input  logic       mem_resp,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_cc,
  output logic       pcmux_sel,
  output logic       marmux_sel,
  output logic       mdrmux_sel,
  output logic [1:0] regfilemux_sel,
  output logic [1:0] alumux_sel,
  output logic       storemux_sel,
  output logic [2:0] aluop,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] mem_byte_enable,
  output logic       mem_error
);

`ifdef LC3B_BYTE_OPS_EN
  localparam logic BYTE_OPS = 1'b1;
`else
  localparam logic BYTE_OPS = 1'b0;
`endif

  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, DECODE, S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKEN,
    S_CALC_ADDR, S_LD1, S_LD2, S_ST1, S_ST2, S_ERROR
  } state_t;

  state_t     state, next_state;
  lc3b_opcode op;
  ctrl_t      ctrl;
  logic       in_wait, expired;

  assign op      = lc3b_opcode'(opcode);
  assign in_wait = (state == FETCH2) || (state == S_LD1) || (state == S_ST2);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_WIDTH(TO_WIDTH)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (!in_wait),
    .mem_resp (mem_resp),
    .expired  (expired)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH1;
    else       state <= next_state;
  end

  // next-state and Moore outputs; outputs held idle while reset is high
  always_comb begin
    ctrl       = CTRL_IDLE;
    next_state = state;
    case (state)
      FETCH1: begin
        ctrl.load_mar   = 1'b1;
        ctrl.marmux_sel = MARMUX_PC;
        ctrl.load_pc    = 1'b1;
        ctrl.pcmux_sel  = PCMUX_PLUS2;
        next_state      = FETCH2;
      end
      FETCH2: begin
        ctrl.mem_read   = 1'b1;
        ctrl.mdrmux_sel = MDRMUX_MEM;
        ctrl.load_mdr   = 1'b1;
        if (mem_resp)     next_state = FETCH3;
        else if (expired) next_state = S_ERROR;
      end
      FETCH3: begin
        ctrl.load_ir = 1'b1;
        next_state   = DECODE;
      end
      DECODE: begin
        case (op)
          op_add:         next_state = S_ADD;
          op_and:         next_state = S_AND;
          op_not:         next_state = S_NOT;
          op_br:          next_state = S_BR;
          op_ldr, op_str: next_state = S_CALC_ADDR;
          op_ldb, op_stb: next_state = BYTE_OPS ? S_CALC_ADDR : FETCH1;
          default:        next_state = FETCH1;
        endcase
      end
      S_ADD, S_AND, S_NOT: begin
        ctrl.aluop          = (state == S_ADD) ? alu_add :
                              (state == S_AND) ? alu_and : alu_not;
        ctrl.alumux_sel     = (state == S_NOT) ? ALUMUX_SR2 : {1'b0, imm_mode};
        ctrl.load_regfile   = 1'b1;
        ctrl.regfilemux_sel = REGMUX_ALU;
        ctrl.load_cc        = 1'b1;
        next_state          = FETCH1;
      end
      S_BR:       next_state = branch_enable ? S_BR_TAKEN : FETCH1;
      S_BR_TAKEN: begin
        ctrl.load_pc   = 1'b1;
        ctrl.pcmux_sel = PCMUX_BRADD;
        next_state     = FETCH1;
      end
      S_CALC_ADDR: begin
        ctrl.alumux_sel = ALUMUX_OFFS6;
        ctrl.aluop      = alu_add;
        ctrl.load_mar   = 1'b1;
        next_state      = is_store_op(op) ? S_ST1 : S_LD1;
      end
      S_LD1: begin
        ctrl.mem_read   = 1'b1;
        ctrl.mdrmux_sel = MDRMUX_MEM;
        ctrl.load_mdr   = 1'b1;
        if (mem_resp)     next_state = S_LD2;
        else if (expired) next_state = S_ERROR;
      end
      S_LD2: begin
        ctrl.load_regfile   = 1'b1;
        ctrl.load_cc        = 1'b1;
        ctrl.regfilemux_sel = (BYTE_OPS && op == op_ldb) ? REGMUX_MDR_B : REGMUX_MDR;
        next_state          = FETCH1;
      end
      S_ST1: begin
        ctrl.storemux_sel = STOREMUX_DR;
        ctrl.mdrmux_sel   = MDRMUX_ALU;
        ctrl.aluop        = alu_pass;
        ctrl.load_mdr     = 1'b1;
        next_state        = S_ST2;
      end
      S_ST2: begin
        ctrl.mem_write = 1'b1;
        if (BYTE_OPS && op == op_stb) ctrl.mem_byte_enable = mar_lsb ? WMASK_HI : WMASK_LO;
        if (mem_resp)     next_state = FETCH1;
        else if (expired) next_state = S_ERROR;
      end
      S_ERROR: ctrl.mem_error = 1'b1;
      default: next_state = FETCH1;
    endcase
    if (reset) ctrl = CTRL_IDLE;
  end

  assign load_pc         = ctrl.load_pc;
  assign load_ir         = ctrl.load_ir;
  assign load_regfile    = ctrl.load_regfile;
  assign load_mar        = ctrl.load_mar;
  assign load_mdr        = ctrl.load_mdr;
  assign load_cc         = ctrl.load_cc;
  assign pcmux_sel       = ctrl.pcmux_sel;
  assign marmux_sel      = ctrl.marmux_sel;
  assign mdrmux_sel      = ctrl.mdrmux_sel;
  assign regfilemux_sel  = ctrl.regfilemux_sel;
  assign alumux_sel      = ctrl.alumux_sel;
  assign storemux_sel    = ctrl.storemux_sel;
  assign aluop           = ctrl.aluop;
  assign mem_read        = ctrl.mem_read;
  assign mem_write       = ctrl.mem_write;
  assign mem_byte_enable = ctrl.mem_byte_enable;
  assign mem_error       = ctrl.mem_error;

endmodule

// File: tb/tb_lc3b_mc_control.sv
// Scoreboard bench for lc3b_mc_control: the stimulus thread queues the
// expected output bundle for each cycle it drives, a negedge monitor pops
// and compares. A second instance with MEM_TIMEOUT=3 covers the timeout.
module tb_lc3b_mc_control;
  import lc3b_types::*;

  typedef struct packed {
    logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
    logic       pcmux, marmux, mdrmux;
    logic [1:0] regfilemux, alumux;
    logic       storemux;
    logic [2:0] aluop;
    logic       mem_read, mem_write;
    logic [1:0] mbe;
    logic       mem_error;
  } outv_t;

  typedef enum {E_IDLE, E_F1, E_F2, E_F3, E_DEC, E_ADD, E_AND, E_NOT, E_BR,
                E_BRT, E_CALC, E_LD1, E_LD2W, E_LD2B, E_ST1, E_ST2W, E_ST2B,
                E_ERR} exp_t;

  typedef struct {
    int    which;
    outv_t want;
    string tag;
  } chk_t;

  logic clk = 1'b0;
  logic reset, imm_mode, branch_enable, mar_lsb, mem_resp;
  logic [3:0] opcode;
  wire [21:0] am, at;

  chk_t  q[$];
  chk_t  c;
  outv_t got;
  int    total = 0;
  int    bad = 0;

  always #5 clk = ~clk;

  lc3b_mc_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .imm_mode(imm_mode),
    .branch_enable(branch_enable), .mar_lsb(mar_lsb), .mem_resp(mem_resp),
    .load_pc(am[21]), .load_ir(am[20]), .load_regfile(am[19]),
    .load_mar(am[18]), .load_mdr(am[17]), .load_cc(am[16]),
    .pcmux_sel(am[15]), .marmux_sel(am[14]), .mdrmux_sel(am[13]),
    .regfilemux_sel(am[12:11]), .alumux_sel(am[10:9]), .storemux_sel(am[8]),
    .aluop(am[7:5]), .mem_read(am[4]), .mem_write(am[3]),
    .mem_byte_enable(am[2:1]), .mem_error(am[0])
  );

  lc3b_mc_control #(.MEM_TIMEOUT(3)) dut_to (
    .clk(clk), .reset(reset), .opcode(opcode), .imm_mode(imm_mode),
    .branch_enable(branch_enable), .mar_lsb(mar_lsb), .mem_resp(mem_resp),
    .load_pc(at[21]), .load_ir(at[20]), .load_regfile(at[19]),
    .load_mar(at[18]), .load_mdr(at[17]), .load_cc(at[16]),
    .pcmux_sel(at[15]), .marmux_sel(at[14]), .mdrmux_sel(at[13]),
    .regfilemux_sel(at[12:11]), .alumux_sel(at[10:9]), .storemux_sel(at[8]),
    .aluop(at[7:5]), .mem_read(at[4]), .mem_write(at[3]),
    .mem_byte_enable(at[2:1]), .mem_error(at[0])
  );

  // hand-written output table per state
  function automatic outv_t ev(exp_t s, logic imm, logic lsb);
    outv_t e = '0;
    e.aluop = alu_pass;
    e.mbe   = 2'b11;
    case (s)
      E_F1:  begin e.load_mar = 1; e.marmux = 1; e.load_pc = 1; end
      E_F2, E_LD1: begin e.mem_read = 1; e.mdrmux = 1; e.load_mdr = 1; end
      E_F3:  e.load_ir = 1;
      E_ADD: begin e.aluop = alu_add; e.alumux = {1'b0, imm}; e.load_regfile = 1; e.load_cc = 1; end
      E_AND: begin e.aluop = alu_and; e.alumux = {1'b0, imm}; e.load_regfile = 1; e.load_cc = 1; end
      E_NOT: begin e.aluop = alu_not; e.load_regfile = 1; e.load_cc = 1; end
      E_BRT: begin e.load_pc = 1; e.pcmux = 1; end
      E_CALC: begin e.alumux = 2'd2; e.aluop = alu_add; e.load_mar = 1; end
      E_LD2W: begin e.load_regfile = 1; e.load_cc = 1; e.regfilemux = 2'd1; end
      E_LD2B: begin e.load_regfile = 1; e.load_cc = 1; e.regfilemux = 2'd2; end
      E_ST1: begin e.storemux = 1; e.load_mdr = 1; end
      E_ST2W: e.mem_write = 1;
      E_ST2B: begin e.mem_write = 1; e.mbe = lsb ? 2'b10 : 2'b01; end
      E_ERR: e.mem_error = 1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic push(int which, exp_t s);
    chk_t n;
    n.which = which;
    n.want  = ev(s, imm_mode, mar_lsb);
    n.tag   = s.name();
    q.push_back(n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(exp_t s);
    push(0, s);
    tick();
  endtask

  task automatic cyc_t(exp_t s);
    push(1, s);
    tick();
  endtask

  task automatic cyc_both(exp_t s);
    push(0, s);
    push(1, s);
    tick();
  endtask

  task automatic fetch(int d, logic [3:0] op);
    opcode   = op;
    mem_resp = 1'b0;
    cyc(E_F1);
    repeat (d) cyc(E_F2);
    mem_resp = 1'b1;
    cyc(E_F2);
    mem_resp = 1'b0;
    cyc(E_F3);
    cyc(E_DEC);
  endtask

  // monitor: compare everything queued for the current cycle
  always @(negedge clk) begin
    while (q.size() > 0) begin
      c   = q.pop_front();
      got = (c.which == 0) ? outv_t'(am) : outv_t'(at);
      total++;
      if (got !== c.want) begin
        bad++;
        $display("FAIL %s dut=%0d t=%0t got=%h want=%h", c.tag, c.which, $time, got, c.want);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; imm_mode = 1'b0; branch_enable = 1'b0; mar_lsb = 1'b0;
    mem_resp = 1'b0; opcode = op_add;
    tick();
    repeat (3) cyc_both(E_IDLE);
    reset = 1'b0;

    fetch(0, op_add);  cyc(E_ADD);
    imm_mode = 1'b1;
    fetch(1, op_add);  cyc(E_ADD);
    imm_mode = 1'b0;
    fetch(0, op_and);  cyc(E_AND);
    imm_mode = 1'b1;
    fetch(0, op_and);  cyc(E_AND);
    imm_mode = 1'b0;
    fetch(0, op_not);  cyc(E_NOT);

    branch_enable = 1'b1;
    fetch(0, op_br);   cyc(E_BR); cyc(E_BRT);
    branch_enable = 1'b0;
    fetch(0, op_br);   cyc(E_BR);

    fetch(0, op_ldr);  cyc(E_CALC);
    repeat (4) cyc(E_LD1);
    mem_resp = 1'b1;   cyc(E_LD1);
    mem_resp = 1'b0;   cyc(E_LD2W);

    fetch(0, op_str);  cyc(E_CALC); cyc(E_ST1);
    mem_resp = 1'b1;   cyc(E_ST2W);
    mem_resp = 1'b0;

`ifdef LC3B_BYTE_OPS_EN
    mar_lsb = 1'b1;
    fetch(0, op_stb);  cyc(E_CALC); cyc(E_ST1);
    mem_resp = 1'b1;   cyc(E_ST2B);
    mem_resp = 1'b0;
    mar_lsb = 1'b0;
    fetch(0, op_stb);  cyc(E_CALC); cyc(E_ST1);
    mem_resp = 1'b1;   cyc(E_ST2B);
    mem_resp = 1'b0;
    fetch(0, op_ldb);  cyc(E_CALC);
    mem_resp = 1'b1;   cyc(E_LD1);
    mem_resp = 1'b0;   cyc(E_LD2B);
`else
    mar_lsb = 1'b1;
    fetch(0, op_stb);
    fetch(0, op_ldb);
    mar_lsb = 1'b0;
`endif

    fetch(0, op_jmp);

    fetch(0, op_str);  cyc(E_CALC); cyc(E_ST1);
    cyc(E_ST2W); cyc(E_ST2W);
    reset = 1'b1;      cyc_both(E_IDLE);
    reset = 1'b0;      cyc_both(E_F1);
    reset = 1'b1;      cyc_both(E_IDLE);
    reset = 1'b0;

    opcode = op_jmp;
    mem_resp = 1'b0;
    cyc_t(E_F1);
    repeat (4) cyc_t(E_F2);
    cyc_t(E_ERR);
    mem_resp = 1'b1;   cyc_t(E_ERR);
    mem_resp = 1'b0;   cyc_t(E_ERR);
    reset = 1'b1;      cyc_t(E_IDLE);
    reset = 1'b0;      cyc_t(E_F1);
    repeat (3) cyc_t(E_F2);
    mem_resp = 1'b1;   cyc_t(E_F2);
    mem_resp = 1'b0;   cyc_t(E_F3);
    cyc_t(E_DEC);
    cyc_t(E_F1);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lc3b_mc_control.md
# lc3b_mc_control

Parametrised multicycle control unit for the LC-3b datapath. It generalises the basic fetch/decode/ADD sequencer in four ways:
- full ALU, load/store and branch sequencing;
- variable-latency memory handshakes with a bounded-wait timeout;
- a sticky error state;
- optional byte load/store.

It sits beside the datapath in the CPU top level and drives every load enable, mux select, ALU op and memory strobe.

## Interface
Parameters:
- MEM_TIMEOUT, default 255: maximum cycles a memory state waits for mem_resp before faulting. Range 1..65535.
- TO_WIDTH, default $clog2(MEM_TIMEOUT+1): timeout counter width. Derived; never overridden.

Ports:
- clk  in  1  system clock. All state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  4  lc3b_opcode from IR[15:12].
- imm_mode  in  1  IR[5]; selects the immediate operand for ADD/AND.
- branch_enable  in  1  NZP match from the CC compare.
- mar_lsb  in  1  MAR[0]; selects the byte lane.
- mem_resp  in  1  memory completion, one-cycle pulse.
- load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc  out  1 each  register load enables.
- pcmux_sel  out  1  0 = PC+2, 1 = branch adder.
- marmux_sel  out  1  0 = alu_out, 1 = PC.
- mdrmux_sel  out  1  0 = alu_out, 1 = mem_rdata.
- regfilemux_sel  out  2  0 = alu_out, 1 = MDR word, 2 = zero-extended MDR byte.
- alumux_sel  out  2  0 = SR2, 1 = sext(imm5), 2 = sext(offset6) shifted by the byte/word rule.
- storemux_sel  out  1  0 = IR[8:6], 1 = IR[11:9] (used as the register-file read source for stores).
- aluop  out  lc3b_aluop  ALU operation.
- mem_read, mem_write  out  1 each  memory strobes.
- mem_byte_enable  out  2  lc3b_mem_wmask.
- mem_error  out  1  sticky timeout flag.

## Operation
Outputs:
- Moore outputs decoded from the current state only.
- Defaults: every load, strobe and mem_error = 0, all selects = 0, aluop = alu_pass, mem_byte_enable = 2'b11.

States and transitions:
- FETCH1: load_mar, marmux_sel=1, load_pc, pcmux_sel=0. Next: FETCH2.
- FETCH2: mem_read, mdrmux_sel=1, load_mdr. Stays until mem_resp, then FETCH3.
- FETCH3: load_ir. Next: DECODE.
- DECODE: dispatch on opcode.
  - ADD/AND/NOT go to S_ADD/S_AND/S_NOT.
  - BR goes to S_BR.
  - LDR/STR go to S_CALC_ADDR.
  - LDB/STB go to S_CALC_ADDR (macro-enabled only).
  - Any other opcode returns to FETCH1 (treated as a NOP).
- S_ADD/S_AND/S_NOT:
  - aluop = add/and/not; alumux_sel = imm_mode for ADD/AND.
  - load_regfile, regfilemux_sel=0, load_cc. Next: FETCH1.
- S_BR: next is S_BR_TAKEN if branch_enable, else FETCH1.
- S_BR_TAKEN: load_pc, pcmux_sel=1. Next: FETCH1.
- S_CALC_ADDR:
  - alumux_sel=2, aluop=alu_add, load_mar.
  - Next: S_LD1 for loads. For stores: S_ST1, which loads MDR from alu_pass of the store register (storemux_sel=1, mdrmux_sel=0).
- S_LD1: mem_read, mdrmux_sel=1, load_mdr. Waits for mem_resp, then S_LD2.
- S_LD2: load_regfile, load_cc, regfilemux_sel = 1 (LDR) or 2 (LDB). Next: FETCH1.
- S_ST1 → S_ST2. S_ST2: mem_write; waits for mem_resp, then FETCH1.
- Byte store: mem_byte_enable = mar_lsb ? 2'b10 : 2'b01.
- S_ERROR: mem_error=1, all strobes 0. Exited only by reset.

Timeout:
- Counter clears on entry to any wait state (FETCH2, S_LD1, S_ST2) and increments each cycle mem_resp is low.
- If the count equals MEM_TIMEOUT with mem_resp low, next state is S_ERROR.
- mem_resp in the same cycle as the count reaching the limit wins: the access completes normally.

## Timing
- Reset: state = FETCH1, counter = 0. While reset is high, all outputs are forced to their defaults (no loads, no strobes).
- The first FETCH1 actions occur in the cycle after reset deasserts.
- Instruction latency with single-cycle mem_resp:
  - ALU ops: 5 cycles.
  - BR not taken: 5. BR taken: 6.
  - LDR/LDB: 7.
  - STR/STB: 7.
- Each extra memory wait cycle adds 1.
- Strobes stay high continuously until the cycle mem_resp is sampled high, and drop the following cycle.
- Reset mid-wait: strobes drop the same cycle; the access is abandoned.

## Configuration
- LC3B_BYTE_OPS_EN defined: LDB/STB decode and sequence as described above, including byte-lane mem_byte_enable and regfilemux_sel=2.
- Undefined: LDB/STB are NOPs (DECODE → FETCH1), regfilemux_sel never equals 2, and mem_byte_enable is always 2'b11.

## Structure
- The lc3b_types package holds lc3b_opcode, lc3b_aluop, lc3b_mem_wmask and the mux-select encodings as named constants.
- The state enum stays local to the module.
- One sub-module, mem_wait_timer (parameter MEM_TIMEOUT; ports clk, reset, clear, mem_resp, expired), isolates the timeout counter.

## Test plan
- Reset held 3 cycles, then released with ADD (imm_mode=0) and mem_resp on the 1st FETCH2 cycle → states FETCH1, FETCH2, FETCH3, DECODE, S_ADD; load_regfile=1 and aluop=alu_add only in cycle 5.
- BR with branch_enable=1 → load_pc with pcmux_sel=1 in cycle 6. With branch_enable=0 → back to FETCH1 at cycle 6 with no second load_pc.
- LDR with mem_resp delayed 4 cycles in S_LD1 → mem_read high for exactly 5 cycles; load_regfile with regfilemux_sel=1 on the following cycle.
- MEM_TIMEOUT=3, mem_resp never asserted in FETCH2 → S_ERROR after 4 FETCH2 cycles; mem_error stays 1 until reset. With mem_resp in the 4th cycle, no error.
- STB, mar_lsb=1, with LC3B_BYTE_OPS_EN defined → mem_write with mem_byte_enable=2'b10. Without the macro → no mem_write; next state FETCH1.
- Reset asserted during an S_ST2 wait → mem_write low in the same cycle; FETCH1 follows release.
